// File: rtl/lu_test_pkg.sv
// Shared types, vector constants and golden model for the logic-unit self-test.
package lu_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } lu_state_t;

    localparam logic [1:0] VEC_00 = 2'b00;
    localparam logic [1:0] VEC_01 = 2'b01;
    localparam logic [1:0] VEC_10 = 2'b10;
    localparam logic [1:0] VEC_11 = 2'b11;

    // {out1, out2} of a healthy datapath
    function automatic logic [1:0] lu_expected(input logic in1, input logic in2);
        return {in1 ^ in2, ~in2};
    endfunction

endpackage

// File: rtl/lu_settle_timer.sv
// Loadable down-counter with zero flag; counts down to zero and holds there.
module lu_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/logic_unit_test_sequencer.sv
// Self-test sequencer: sweeps the 2-input logic datapath and scores it
// against the golden model.
module logic_unit_test_sequencer
    import lu_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_out1,
    input  logic             dut_out2,
    output logic             dut_in1,
    output logic             dut_in2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [LW-1:0]    LOOP_LAST   = LW'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    lu_state_t        state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [LW-1:0]    loop_q, loop_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;
    logic             pass_q, pass_d;
    logic             load;
    logic             zero;
    logic             bad;

    lu_settle_timer #(
        .W(CW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .load_val(SETTLE_LOAD),
        .zero    (zero)
    );

    assign bad = ({dut_out1, dut_out2} != lu_expected(vec_q[1], vec_q[0]));

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        loop_d  = loop_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    vec_d   = VEC_00;
                    loop_d  = '0;
                    load    = 1'b1;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    vec_d   = VEC_00;
                    pass_d  = 1'b0;
                end else if (zero) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // abort discards this sample and beats the move to DONE
                if (abort) begin
                    state_d = ST_IDLE;
                    vec_d   = VEC_00;
                    pass_d  = 1'b0;
                end else begin
                    if (bad) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        fail_d[vec_q] = 1'b1;
                    end
                    if (vec_q != VEC_11) begin
                        vec_d   = vec_q + 2'd1;
                        load    = 1'b1;
                        state_d = ST_SETTLE;
                    end else if (loop_q != LOOP_LAST) begin
                        loop_d  = loop_q + LW'(1);
                        vec_d   = VEC_00;
                        load    = 1'b1;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_DONE;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                vec_d   = VEC_00;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            loop_q  <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            loop_q  <= loop_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    assign dut_in1   = vec_q[1];
    assign dut_in2   = vec_q[0];
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule
